// File: rtl/addsub_pipe_stage_pkg.sv
// addsub_pipe_stage_pkg: widths, opcodes, flag indices and opcode decode helpers
package addsub_pipe_stage_pkg;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic op_inv(input logic [1:0] op);
    return op == OP_SUB || op == OP_SBB;
  endfunction
  function automatic logic op_chain(input logic [1:0] op);
    return op == OP_ADC || op == OP_SBB;
  endfunction
endpackage

// File: rtl/addsub_pipe_stage_if.sv
// addsub_pipe_stage_if: request/result handshake bundle for the add/sub pipeline
interface addsub_pipe_stage_if;
  import addsub_pipe_stage_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             carry_q;
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, out_tag, carry_q
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_flags, out_tag, carry_q
  );
endinterface

// File: rtl/addsub_pipe_stage_adder.sv
// thirtyTwoBitAdder: 32-bit adder of 4-bit lookahead groups chained by group generate/propagate
module thirtyTwoBitAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p, c;
  logic [8:0]  gc;
  assign g = a & b;
  assign p = a ^ b;
  assign gc[0] = cin;
  for (genvar k = 0; k < 8; k++) begin : grp
    localparam int L = 4 * k;
    assign c[L]     = gc[k];
    assign c[L+1]   = g[L] | (p[L] & gc[k]);
    assign c[L+2]   = g[L+1] | (p[L+1] & g[L]) | (&p[L+1:L] & gc[k]);
    assign c[L+3]   = g[L+2] | (p[L+2] & g[L+1]) | (&p[L+2:L+1] & g[L]) | (&p[L+2:L] & gc[k]);
    assign gc[k+1]  = g[L+3] | (p[L+3] & g[L+2]) | (&p[L+3:L+2] & g[L+1]) | (&p[L+3:L+1] & g[L])
                    | (&p[L+3:L] & gc[k]);
  end
  assign sum  = p ^ c;
  assign cout = gc[8];
endmodule

// File: rtl/addsub_pipe_stage.sv
// addsub_pipe_stage: two-stage valid/ready add/sub pipeline with sticky carry for ADC/SBB chains
module addsub_pipe_stage
  import addsub_pipe_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  addsub_pipe_stage_if.slave bus
);
  logic             s1_valid_q, s1_valid_d, cin_q, cin_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
  logic             out_valid_q, out_valid_d, carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d, add_sum;
  logic [3:0]       flags_q, flags_d, flags_new;
  logic             add_cout, s2_adv, s1_adv, in_rdy, acc, c_fwd;
  thirtyTwoBitAdder u_add (.a(a_q), .b(b_q), .cin(cin_q), .sum(add_sum), .cout(add_cout));
  always_comb begin
    s2_adv      = !out_valid_q || bus.out_ready;
    s1_adv      = s1_valid_q && s2_adv;
    in_rdy      = !s1_valid_q || s2_adv;
    acc         = bus.in_valid && in_rdy;
    c_fwd       = s1_adv ? add_cout : carry_q;
    flags_new            = '0;
    flags_new[FLAG_N]    = add_sum[WIDTH-1];
    flags_new[FLAG_Z]    = add_sum == '0;
    flags_new[FLAG_C]    = add_cout;
    flags_new[FLAG_V]    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
    s1_valid_d  = acc || (s1_valid_q && !s1_adv);
    a_d         = acc ? bus.in_a : a_q;
    b_d         = acc ? (op_inv(bus.in_op) ? ~bus.in_b : bus.in_b) : b_q;
    cin_d       = acc ? (op_chain(bus.in_op) ? c_fwd : op_inv(bus.in_op)) : cin_q;
    tag_d       = acc ? bus.in_tag : tag_q;
    out_valid_d = s1_adv || (out_valid_q && !bus.out_ready);
    sum_d       = s1_adv ? add_sum : sum_q;
    flags_d     = s1_adv ? flags_new : flags_q;
    otag_d      = s1_adv ? tag_q : otag_q;
    carry_d     = s1_adv ? add_cout : carry_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
      otag_q      <= '0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      otag_q      <= otag_d;
      carry_q     <= carry_d;
    end
  end
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_flags = flags_q;
  assign bus.out_tag   = otag_q;
  assign bus.carry_q   = carry_q;
endmodule
